spi_accel_responder: RTL and testbench
======================================

Name: spi_accel_responder

Overview:
- SPI target (slave) that emulates the 3-axis accelerometer seen by the SPI master/sequencer path: WHO_AM_I, the control registers and the OUT_X/Y/Z data registers.
- Used in co-simulation and on-board loopback so the sequencer can run closed-loop without the physical sensor.
- Oversamples the SPI pins with clk_in; fully synchronous internally.
- OUT_X_L follows a deterministic pattern that advances once per frame that reads it.

Parameters:
- WHO_AM_I_VAL, 8'h33, value returned from address 0x0F.
- X_L_INIT, 8'h9A, OUT_X_L value after reset.
- X_L_STEP, 8'h20, increment applied to OUT_X_L after each qualifying frame.
- CTRL_REG1_RST, 8'h07, reset value of CTRL_REG1 (0x20).

Ports:
- clk_in  in  1  system clock; oversamples SPI pins.
- nrst  in  1  reset, asynchronous, active-low.
- spi_sclk  in  1  SPI clock, mode 3 (idles high).
- spi_cs_n  in  1  chip select, active-low.
- spi_mosi  in  1  master-to-target data.
- spi_miso  out  1  target-to-master data.
- spi_miso_oe  out  1  MISO drive enable; 0 means the top level tri-states the pin.
- frame_done  out  1  1-cycle pulse on a clean frame end.
- frame_err  out  1  1-cycle pulse on an aborted frame (CS rise mid-byte).
- ctrl_reg1  out  8  current CTRL_REG1 contents, for debug/LEDs.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, frame_done=0, frame_err=0, ctrl_reg1=CTRL_REG1_RST, TEMP_CFG(0x1F)=0x00, CTRL_REG4(0x23)=0x00, OUT_X_L=X_L_INIT, FSM=IDLE.
- Pin capture: sclk, cs_n and mosi each pass through a 2-FF synchronizer. A third flop provides edge detection. Edge-to-action latency is 3 clk_in cycles.
- Speed requirement: each SCLK half-period must be at least 4 clk_in cycles. Faster SCLK is not supported and is not detected.
- Mode 3 timing: MOSI is sampled on each SCLK rising edge; MISO is updated on each SCLK falling edge.
- Frame format:
  - Byte 0 is the command: bit7=RW (1=read), bit6=MS (1=auto-increment), bits5:0=address.
  - Subsequent bytes are data, MSB first.
- FSM states: IDLE, CMD, DATA.
  - IDLE -> CMD on cs_n falling edge; clears the bit counter and the shift-in register.
  - CMD: on the 8th rising edge, latch RW/MS/addr and go to DATA. If RW=1, load the output shift register with reg[addr] on that same cycle.
  - DATA, write: on each 8th rising edge, commit the byte to addr (only if writable); if MS=1, addr <= addr+1 (6-bit wrap).
  - DATA, read: on each falling edge, spi_miso <= shift_out[7], shift left, spi_miso_oe <= 1. On each 8th rising edge, if MS=1 then addr+1, and reload shift_out with reg[new addr].
  - Any state -> IDLE on cs_n rising edge; spi_miso_oe <= 0 on the same cycle.
- Read enable window: spi_miso_oe stays 0 throughout the command byte and throughout write frames. A write frame therefore reads back as high-Z.
- Register map:
  - 0x0F = WHO_AM_I_VAL, read-only.
  - 0x1F, 0x20, 0x23: read/write.
  - 0x28 = OUT_X_L.
  - 0x29/0x2B/0x2D (OUT_X_H/OUT_Y_H/OUT_Z_H) = 0x00.
  - 0x2A = OUT_X_L ^ 0xFF; 0x2C = OUT_X_L + 0x40 (8-bit wrap).
  - All other addresses read 0x00; writes to them and to read-only registers are ignored.
- Read data is snapshotted at load time. A pattern update never changes a byte already being shifted out.
- Pattern advance: at cs_n rise, if the frame completed at least one full read byte from address 0x28, OUT_X_L <= OUT_X_L + X_L_STEP (8-bit wrap). This happens once per frame regardless of how many times 0x28 was read.
- Frame end:
  - If cs_n rises with bit count a multiple of 8 (including 0), pulse frame_done.
  - Otherwise pulse frame_err, discard the partial byte (no write commit) and do not advance the pattern unless an earlier byte qualified.
- cs_n high: SCLK edges are ignored.
- cs_n falling and SCLK edge detected in the same cycle: the SCLK edge is ignored.
- nrst asserted mid-frame: immediate return to reset values. The next frame starts only on a fresh cs_n falling edge.

Test Plan:
- Read WHO_AM_I: 16-bit frame, MOSI 0x8F00 -> MISO byte1=0x33; oe=0 during byte0; frame_done pulse.
- Write CTRL_REG1: 16-bit frame 0x2077 -> oe=0 for the whole frame; ctrl_reg1=0x77 after frame. A following read 0xA0 returns 0x77.
- Auto-increment read: three successive 24-bit frames 0xE80000 -> bytes [15:8]=0x9A,0xBA,0xDA; bytes [7:0]=0x00.
- Pattern boundaries:
  - Read 0x2A with OUT_X_L=0x9A -> 0x65.
  - Eight reads of 0x28 -> 8th returns 0x7A (wrap).
  - Read of 0x28 with MS=0 over 3 data bytes -> 0x9A three times, one advance only.
- Aborted frame: write 0x23 with cs_n raised after 12 bits -> frame_err pulse; CTRL_REG4 stays 0x00; next frame works normally.
- Reset mid-read: nrst low during byte1 of a 0x8F read -> oe=0 immediately, registers at reset values; the next 0x8F frame returns 0x33.

Source files
------------

// File: rtl/spi_accel_responder.sv
// spi_accel_responder
//   SPI mode-3 target that stands in for a 3-axis accelerometer, so the SPI
//   sequencer can run closed-loop without the physical sensor. The SPI pins are
//   oversampled with clk_in, and all logic runs in the clk_in domain.
//   Each SCLK half-period must be at least 4 clk_in cycles.
//
// Ports
//   clk_in       system clock; oversamples the SPI pins
//   nrst         asynchronous active-low reset
//   spi_sclk     SPI clock (mode 3, idles high)
//   spi_cs_n     chip select, active-low
//   spi_mosi     master-to-target data
//   spi_miso     target-to-master data
//   spi_miso_oe  MISO drive enable; the top level tri-states the pin when 0
//   frame_done   1-cycle pulse when a frame ends on a byte boundary
//   frame_err    1-cycle pulse when a frame is aborted mid-byte
//   ctrl_reg1    current CTRL_REG1 contents

module spi_accel_responder #(
  parameter logic [7:0] WHO_AM_I_VAL  = 8'h33,
  parameter logic [7:0] X_L_INIT      = 8'h9A,
  parameter logic [7:0] X_L_STEP      = 8'h20,
  parameter logic [7:0] CTRL_REG1_RST = 8'h07
) (
  input  logic       clk_in,
  input  logic       nrst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] ctrl_reg1
);

  localparam logic [5:0] AddrWhoAmI   = 6'h0F;
  localparam logic [5:0] AddrTempCfg  = 6'h1F;
  localparam logic [5:0] AddrCtrlReg1 = 6'h20;
  localparam logic [5:0] AddrCtrlReg4 = 6'h23;
  localparam logic [5:0] AddrOutXL    = 6'h28;
  localparam logic [5:0] AddrOutYL    = 6'h2A;
  localparam logic [5:0] AddrOutZL    = 6'h2C;

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  // Pin synchronizers: s1/s2 form the 2-FF synchronizer, s3 is the edge-detect history.
  // The cs_n chain resets low: if cs_n is already low when reset is released, no
  // falling edge is seen and the responder waits for a fresh frame. A high cs_n
  // instead shows up as a rising edge, which is ignored in StIdle.
  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic mosi_s1, mosi_s2;

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      sclk_s1 <= 1'b1;
      sclk_s2 <= 1'b1;
      sclk_s3 <= 1'b1;
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      cs_s3   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= spi_cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign cs_rise   = cs_s2 & ~cs_s3;
  assign cs_fall   = ~cs_s2 & cs_s3;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_in_q;
  logic [7:0] shift_out_q;
  logic       rw_q;
  logic       ms_q;
  logic [5:0] addr_q;
  logic       x_qual_q;  // a full OUT_X_L read byte has completed in this frame
  logic [7:0] temp_cfg_q;
  logic [7:0] ctrl_reg4_q;
  logic [7:0] out_x_l_q;

  // Byte as it stands once the current rising-edge bit is included.
  logic [7:0] byte_in;
  logic [5:0] addr_next;
  assign byte_in   = {shift_in_q[6:0], mosi_s2};
  assign addr_next = ms_q ? addr_q + 6'd1 : addr_q;

  function automatic logic [7:0] rd_data(input logic [5:0] a,     input logic [7:0] x_l,
                                         input logic [7:0] temp,  input logic [7:0] c1,
                                         input logic [7:0] c4);
    logic [7:0] d;
    d = 8'h00;
    case (a)
      AddrWhoAmI:   d = WHO_AM_I_VAL;
      AddrTempCfg:  d = temp;
      AddrCtrlReg1: d = c1;
      AddrCtrlReg4: d = c4;
      AddrOutXL:    d = x_l;
      AddrOutYL:    d = x_l ^ 8'hFF;
      AddrOutZL:    d = x_l + 8'h40;
      default:      d = 8'h00;
    endcase
    return d;
  endfunction

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 8'h00;
      shift_out_q <= 8'h00;
      rw_q        <= 1'b0;
      ms_q        <= 1'b0;
      addr_q      <= 6'h00;
      x_qual_q    <= 1'b0;
      temp_cfg_q  <= 8'h00;
      ctrl_reg1   <= CTRL_REG1_RST;
      ctrl_reg4_q <= 8'h00;
      out_x_l_q   <= X_L_INIT;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (state_q != StIdle && cs_rise) begin
        // Frame end; an SCLK edge in this same cycle is dropped, so a partial byte never commits.
        state_q     <= StIdle;
        spi_miso_oe <= 1'b0;
        if (bit_cnt_q == 3'd0) frame_done <= 1'b1;
        else                   frame_err  <= 1'b1;
        if (x_qual_q) out_x_l_q <= out_x_l_q + X_L_STEP;
      end else if (state_q == StIdle) begin
        if (cs_fall) begin
          state_q    <= StCmd;
          bit_cnt_q  <= 3'd0;
          shift_in_q <= 8'h00;
          x_qual_q   <= 1'b0;
        end
      end else if (sclk_rise) begin
        shift_in_q <= byte_in;
        bit_cnt_q  <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (state_q == StCmd) begin
            state_q <= StData;
            rw_q    <= byte_in[7];
            ms_q    <= byte_in[6];
            addr_q  <= byte_in[5:0];
            if (byte_in[7]) begin
              shift_out_q <= rd_data(byte_in[5:0], out_x_l_q, temp_cfg_q, ctrl_reg1,
                                     ctrl_reg4_q);
            end
          end else if (rw_q) begin
            if (addr_q == AddrOutXL) x_qual_q <= 1'b1;
            addr_q      <= addr_next;
            shift_out_q <= rd_data(addr_next, out_x_l_q, temp_cfg_q, ctrl_reg1, ctrl_reg4_q);
          end else begin
            case (addr_q)
              AddrTempCfg:  temp_cfg_q  <= byte_in;
              AddrCtrlReg1: ctrl_reg1   <= byte_in;
              AddrCtrlReg4: ctrl_reg4_q <= byte_in;
              default:      ;
            endcase
            addr_q <= addr_next;
          end
        end
      end else if (sclk_fall && state_q == StData && rw_q) begin
        spi_miso    <= shift_out_q[7];
        shift_out_q <= {shift_out_q[6:0], 1'b0};
        spi_miso_oe <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_accel_responder.sv
module tb_spi_accel_responder;

  logic       clk_in = 1'b0;
  logic       nrst = 1'b0;
  logic       spi_sclk = 1'b1;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       frame_done;
  logic       frame_err;
  logic [7:0] ctrl_reg1;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  spi_accel_responder dut (
    .clk_in      (clk_in),
    .nrst        (nrst),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .ctrl_reg1   (ctrl_reg1)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err)  err_cnt  <= err_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk_in);
    nrst = 1'b1;
    repeat (3) @(negedge clk_in);
  endtask

  // Clocks n bits MSB-first; rx/oe capture MISO and OE just before each rising edge.
  task automatic spi_bits(input logic [31:0] tx, input int n,
                          output logic [31:0] rx, output logic [31:0] oe);
    rx = '0;
    oe = '0;
    for (int i = 0; i < n; i++) begin
      spi_sclk = 1'b0;
      spi_mosi = tx[n-1-i];
      repeat (8) @(negedge clk_in);
      rx[n-1-i] = spi_miso;
      oe[n-1-i] = spi_miso_oe;
      spi_sclk = 1'b1;
      repeat (8) @(negedge clk_in);
    end
  endtask

  task automatic spi_frame(input logic [31:0] tx, input int n,
                           output logic [31:0] rx, output logic [31:0] oe);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk_in);
    spi_bits(tx, n, rx, oe);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk_in);
  endtask

  logic [31:0] rx, oe;
  int d0, e0;

  initial begin
    repeat (3) @(negedge clk_in);
    check_val("rst_miso", {31'd0, spi_miso}, 32'd0);
    check_val("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check_val("rst_done", {31'd0, frame_done}, 32'd0);
    check_val("rst_err", {31'd0, frame_err}, 32'd0);
    check_val("rst_ctrl1", {24'd0, ctrl_reg1}, 32'h07);
    nrst = 1'b1;
    repeat (3) @(negedge clk_in);

    // WHO_AM_I
    d0 = done_cnt; e0 = err_cnt;
    spi_frame(32'h8F00, 16, rx, oe);
    check_val("whoami_data", {24'd0, rx[7:0]}, 32'h33);
    check_val("whoami_oe_cmd", {24'd0, oe[15:8]}, 32'h00);
    check_val("whoami_oe_data", {24'd0, oe[7:0]}, 32'hFF);
    check_val("whoami_done", done_cnt - d0, 1);
    check_val("whoami_err", err_cnt - e0, 0);

    // Writes, read-back, read-only protection
    spi_frame(32'h2077, 16, rx, oe);
    check_val("wr_ctrl1_oe", {16'd0, oe[15:0]}, 32'h0);
    check_val("wr_ctrl1_val", {24'd0, ctrl_reg1}, 32'h77);
    spi_frame(32'hA000, 16, rx, oe);
    check_val("rd_ctrl1", {24'd0, rx[7:0]}, 32'h77);
    spi_frame(32'h1F5A, 16, rx, oe);
    spi_frame(32'h9F00, 16, rx, oe);
    check_val("rd_temp_cfg", {24'd0, rx[7:0]}, 32'h5A);
    spi_frame(32'h0F12, 16, rx, oe);
    spi_frame(32'h8F00, 16, rx, oe);
    check_val("ro_whoami", {24'd0, rx[7:0]}, 32'h33);

    // Auto-increment reads, pattern advancing once per frame
    do_reset();
    spi_frame(32'hE80000, 24, rx, oe);
    check_val("ainc0_xl", {24'd0, rx[15:8]}, 32'h9A);
    check_val("ainc0_xh", {24'd0, rx[7:0]}, 32'h00);
    spi_frame(32'hE80000, 24, rx, oe);
    check_val("ainc1_xl", {24'd0, rx[15:8]}, 32'hBA);
    spi_frame(32'hE80000, 24, rx, oe);
    check_val("ainc2_xl", {24'd0, rx[15:8]}, 32'hDA);
    check_val("ainc2_xh", {24'd0, rx[7:0]}, 32'h00);

    // Derived registers, then the wrap of OUT_X_L
    do_reset();
    spi_frame(32'hAA00, 16, rx, oe);
    check_val("rd_y_l", {24'd0, rx[7:0]}, 32'h65);
    spi_frame(32'hAC00, 16, rx, oe);
    check_val("rd_z_l", {24'd0, rx[7:0]}, 32'hDA);
    for (int i = 0; i < 8; i++) begin
      spi_frame(32'hA800, 16, rx, oe);
      check_val($sformatf("xl_seq%0d", i), {24'd0, rx[7:0]}, 32'(8'(8'h9A + 8'h20 * i)));
    end

    // MS=0 repeated read: same snapshot each byte, single advance
    do_reset();
    spi_frame(32'hA8000000, 32, rx, oe);
    check_val("ms0_b1", {24'd0, rx[23:16]}, 32'h9A);
    check_val("ms0_b2", {24'd0, rx[15:8]}, 32'h9A);
    check_val("ms0_b3", {24'd0, rx[7:0]}, 32'h9A);
    spi_frame(32'hA800, 16, rx, oe);
    check_val("ms0_next", {24'd0, rx[7:0]}, 32'hBA);

    // Aborted write to CTRL_REG4 after 12 bits
    d0 = done_cnt; e0 = err_cnt;
    spi_frame(32'h235, 12, rx, oe);
    check_val("abort_err", err_cnt - e0, 1);
    check_val("abort_done", done_cnt - d0, 0);
    d0 = done_cnt;
    spi_frame(32'hA300, 16, rx, oe);
    check_val("abort_ctrl4", {24'd0, rx[7:0]}, 32'h00);
    check_val("abort_next_done", done_cnt - d0, 1);

    // Reset in the middle of a read
    spi_frame(32'h2077, 16, rx, oe);
    spi_frame(32'h1F5A, 16, rx, oe);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk_in);
    spi_bits(32'h8F0, 12, rx, oe);
    check_val("midrd_oe_before", {31'd0, spi_miso_oe}, 32'd1);
    nrst = 1'b0;
    #1;
    check_val("midrd_oe", {31'd0, spi_miso_oe}, 32'd0);
    check_val("midrd_ctrl1", {24'd0, ctrl_reg1}, 32'h07);
    repeat (2) @(negedge clk_in);
    spi_cs_n = 1'b1;
    repeat (2) @(negedge clk_in);
    nrst = 1'b1;
    repeat (4) @(negedge clk_in);
    spi_frame(32'h9F00, 16, rx, oe);
    check_val("midrd_temp_cfg", {24'd0, rx[7:0]}, 32'h00);
    spi_frame(32'h8F00, 16, rx, oe);
    check_val("midrd_whoami", {24'd0, rx[7:0]}, 32'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
